// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_ctrl
// Purpose  : Slews the PWM high-time register toward a target in fixed steps,
//            one update every N PWM periods, for soft-start / soft-stop.
// Revision : 1.0  initial release
// ============================================================================
module pwm_ramp_ctrl #(
  parameter int WIDTH  = 16,
  parameter int HOLD_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              period_tick,
  input  logic              start,
  input  logic              abort,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic [WIDTH-1:0]  target,
  input  logic [WIDTH-1:0]  step,
  input  logic [HOLD_W-1:0] hold_periods,
  output logic [WIDTH-1:0]  pwm_high,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RAMP = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0]  c_STEP_MIN = WIDTH'(1);
  localparam logic [HOLD_W-1:0] c_HOLD_MIN = HOLD_W'(1);

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  pwm_high_q, pwm_high_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [WIDTH-1:0]  step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [HOLD_W:0]   w_hold_inc;
  logic              w_hold_met;
  logic [WIDTH:0]    w_diff_up;
  logic [WIDTH:0]    w_diff_dn;
  logic [WIDTH:0]    w_step_ext;
  logic [WIDTH-1:0]  w_next_val;
  logic              w_update;
  logic              w_accept;

  // Hold counting is done one bit wider so hold_cnt+1 can never wrap.
  assign w_hold_inc = {1'b0, hold_cnt_q} + {{HOLD_W{1'b0}}, 1'b1};
  assign w_hold_met = (w_hold_inc >= {1'b0, hold_q});

  assign w_diff_up  = {1'b0, target_q} - {1'b0, pwm_high_q};
  assign w_diff_dn  = {1'b0, pwm_high_q} - {1'b0, target_q};
  assign w_step_ext = {1'b0, step_q};

  // Clamp to target whenever the remaining distance fits in one step, so the
  // value can neither overshoot nor wrap at either end of the range.
  always_comb begin
    w_next_val = target_q;
    if (target_q > pwm_high_q) begin
      if (w_diff_up > w_step_ext) begin
        w_next_val = pwm_high_q + step_q;
      end
    end else if (target_q < pwm_high_q) begin
      if (w_diff_dn > w_step_ext) begin
        w_next_val = pwm_high_q - step_q;
      end
    end
  end

  assign w_update = (state_q == c_ST_RAMP) && !abort && period_tick && w_hold_met;
  assign w_accept = (state_q == c_ST_IDLE) && !load && start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (w_accept) begin
          state_d = (target == pwm_high_q) ? c_ST_DONE : c_ST_RAMP;
        end
      end
      c_ST_RAMP: begin
        if (abort) begin
          state_d = c_ST_IDLE;
        end else if (w_update && (w_next_val == target_q)) begin
          state_d = c_ST_DONE;
        end
      end
      c_ST_DONE: state_d = c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != c_ST_IDLE);
    done     = (state_q == c_ST_DONE);
    pwm_high = pwm_high_q;
  end

  always_comb begin
    pwm_high_d = pwm_high_q;
    target_d   = target_q;
    step_d     = step_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      c_ST_IDLE: begin
        if (load) begin
          pwm_high_d = load_value;
        end else if (start) begin
          target_d   = target;
          step_d     = (step == '0) ? c_STEP_MIN : step;
          hold_d     = (hold_periods == '0) ? c_HOLD_MIN : hold_periods;
          hold_cnt_d = '0;
        end
      end
      c_ST_RAMP: begin
        if (!abort && period_tick) begin
          if (w_hold_met) begin
            hold_cnt_d = '0;
            pwm_high_d = w_next_val;
          end else begin
            hold_cnt_d = w_hold_inc[HOLD_W-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_high_q <= '0;
      target_q   <= '0;
      step_q     <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      pwm_high_q <= pwm_high_d;
      target_q   <= target_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Sequencer for the PWM high-time register: on a start command it slews the PWM high-time value from its current setting to a target, in fixed-size steps, once every N PWM periods. Its output drives the PWM generator's high-time input in place of a static register, giving soft-start and soft-stop for loads driven from the IO block. All updates happen on PWM period boundaries, so the generator never sees a mid-period change.

## Interface

Parameters:
- WIDTH, 16, width of high-time, target and step values.
- HOLD_W, 8, width of the hold-period count.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- period_tick  in  1  one-cycle pulse at each PWM period boundary.
- start  in  1  one-cycle command to begin a ramp; honoured only in IDLE.
- abort  in  1  stops an active ramp.
- load  in  1  in IDLE, writes load_value directly to pwm_high.
- load_value  in  WIDTH  direct-write value.
- target  in  WIDTH  final high-time; latched on an accepted start.
- step  in  WIDTH  increment per update; latched on an accepted start.
- hold_periods  in  HOLD_W  number of period_ticks between updates; latched on an accepted start.
- pwm_high  out  WIDTH  registered high-time to the PWM generator.
- busy  out  1  high in RAMP and DONE.
- done  out  1  one-cycle pulse when a ramp completes.

## Operation

- States: IDLE, RAMP, DONE. busy = (state != IDLE). done = (state == DONE).
- Reset values:
  - state IDLE.
  - pwm_high 0, busy 0, done 0.
  - hold counter 0, latched target/step/hold all 0.
- IDLE:
  - load has priority over start. load=1 sets pwm_high <= load_value and stays in IDLE.
  - On start (and no load), latch target, step_eff and hold_eff, and clear the hold counter.
    - step_eff = (step==0) ? 1 : step.
    - hold_eff = (hold_periods==0) ? 1 : hold_periods.
  - After an accepted start, go to DONE if target == pwm_high, else go to RAMP.
  - load and start are ignored outside IDLE.
- RAMP:
  - abort=1: go to IDLE. pwm_high keeps its current value, no done pulse. abort beats period_tick in the same cycle.
  - period_tick=1 with hold_cnt+1 < hold_eff: increment hold_cnt.
  - period_tick=1 with hold_cnt+1 >= hold_eff: clear hold_cnt and update pwm_high one step toward the latched target.
  - Update rule, upward (target > pwm_high): if target − pwm_high <= step_eff then pwm_high <= target, else pwm_high <= pwm_high + step_eff.
  - Update rule, downward: the mirror image. The value never overshoots the target, never wraps past 0, and never wraps past 2^WIDTH−1.
  - Arithmetic: differences are computed at WIDTH+1 bits, unsigned.
  - When the updated value equals target, go to DONE on the same edge.
- DONE: held for exactly one cycle, then IDLE. start and abort are ignored in DONE.
- Input changes: changing target, step or hold_periods during RAMP has no effect, because values are latched at start.
- abort in IDLE or DONE has no effect.

## Timing

- start sampled on edge k: busy=1 from cycle k+1.
- Final update on edge m: pwm_high = target and done=1 during cycle m+1. On edge m+1, busy and done fall.
- Start with target == pwm_high: done=1 in cycle k+1, busy low again from k+2.
- pwm_high changes only on:
  - an edge that samples period_tick with the hold condition met (RAMP);
  - a load edge (IDLE);
  - reset.
- pwm_high is glitch-free: it is a plain register with no combinational path from inputs.
- Latency from start to first change: exactly hold_eff period_ticks after the start cycle. A tick in the same cycle as start is not counted.
- Reset mid-ramp: immediately returns to IDLE with pwm_high=0. No done pulse.

## Test plan

- Up-ramp: load 0, start target=100 step=30 hold=2, tick every 10 cycles.
  - Required: pwm_high 30, 60, 90, 100 on every second tick.
  - Required: done one cycle after 100, busy low the next cycle.
- Down-ramp with step 0: load 5, start target=2 step=0 hold=0.
  - Required: pwm_high 4, 3, 2 on consecutive ticks (step treated as 1).
  - Required: no underflow, done pulses once.
- Boundaries: load 0xFFF0, start target=0xFFFF step=0x20. Required: single update to 0xFFFF with no wrap. Then start target=0xFFFF again. Required: done in the next cycle with no tick needed.
- Abort: mid-ramp at pwm_high=60, assert abort together with a qualifying period_tick.
  - Required: pwm_high stays 60, IDLE next cycle.
  - Required: done never asserts.
- Ignored commands: start and load issued during RAMP and during DONE.
  - Required: latched values are unchanged and pwm_high is unaffected.
  - Required: load and start in the same IDLE cycle apply only the load.
- Asynchronous reset mid-ramp (asserted between clock edges). Required: pwm_high=0, busy=0, done=0 immediately. Required: a new start after release ramps normally from 0.
